// File: rtl/sync_master_if.sv
// ----------------------------------------------------------------------------
// sync_master_if
// Four-phase sync/ack handshake bundle between an initiator and a responder.
//   sync      initiator -> responder  request level
//   data_out  initiator -> responder  operand, stable while sync=1
//   ack       responder -> initiator  acknowledge level
//   data_in   responder -> initiator  result, valid while ack=1
// Handshake: the initiator raises sync only while ack=0; the responder
// raises ack with data_in valid; the initiator captures data_in and drops
// sync; the responder drops ack. One transfer per full sync/ack cycle.
// ----------------------------------------------------------------------------
interface sync_master_if #(
  parameter int OUT_WIDTH = 32,
  parameter int IN_WIDTH  = 32
);
  logic                 sync;
  logic                 ack;
  logic [OUT_WIDTH-1:0] data_out;
  logic [IN_WIDTH-1:0]  data_in;

  modport master (output sync, output data_out, input ack, input data_in);
  modport slave  (input sync, input data_out, output ack, output data_in);
endinterface

// File: rtl/sync_master.sv
// ----------------------------------------------------------------------------
// sync_master
// Initiator of the four-phase sync/ack handshake. A start request launches a
// burst of n_trans back-to-back transactions; each result is fed back as the
// next operand. Final result, transaction count and status go to the local
// controller.
//
// Optional feature macro: HANDSHAKE_TIMEOUT_EN
//   defined   - per-phase ack timeout of TIMEOUT_CYCLES aborts the burst and
//               raises error.
//   undefined - waits indefinitely, error is tied to 0.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   start               burst request, sampled in IDLE with ack=0 only
//   n_trans, seed       burst length and first operand
//   busy, done, error   burst in progress / one-cycle end pulse / timeout
//   result, count       last captured data / completed transactions
//   state_dbg           current FSM state (IDLE=0 REQ=1 REL=2 DONE=3)
//   hs                  handshake bundle (master side)
// ----------------------------------------------------------------------------
module sync_master #(
  parameter int OUT_WIDTH      = 32,
  parameter int IN_WIDTH       = 32,
  parameter int N_WIDTH        = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [N_WIDTH-1:0]   n_trans,
  input  logic [OUT_WIDTH-1:0] seed,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [IN_WIDTH-1:0]  result,
  output logic [N_WIDTH-1:0]   count,
  output logic [1:0]           state_dbg,
  sync_master_if.master        hs
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_REL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]           state_q, state_d;
  logic                 sync_q, sync_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic [IN_WIDTH-1:0]  result_q, result_d;
  logic [N_WIDTH-1:0]   count_q, count_d;
  logic [N_WIDTH-1:0]   n_q, n_d;
  logic [OUT_WIDTH-1:0] data_out_q, data_out_d;
  logic [OUT_WIDTH-1:0] feedback;
  logic [N_WIDTH-1:0]   count_inc;

  // Responder data resized to operand width: truncated or zero-extended.
  assign feedback  = OUT_WIDTH'(hs.data_in);
  assign count_inc = count_q + N_WIDTH'(1);

`ifdef HANDSHAKE_TIMEOUT_EN
  localparam int PH_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [PH_W-1:0] phase_q, phase_d;
  logic            phase_expired;
  assign phase_expired = (phase_q == PH_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d    = state_q;
    sync_d     = sync_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    result_d   = result_q;
    count_d    = count_q;
    n_d        = n_q;
    data_out_d = data_out_q;
    case (state_q)
      S_IDLE: begin
        // Gating on ack=0 guarantees sync never rises against a high ack.
        if (start && !hs.ack) begin
          data_out_d = seed;
          n_d        = n_trans;
          count_d    = '0;
          error_d    = 1'b0;
          busy_d     = 1'b1;
          if (n_trans != '0) begin
            sync_d  = 1'b1;
            state_d = S_REQ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_REQ: begin
        if (hs.ack) begin
          result_d   = hs.data_in;
          data_out_d = feedback;
          sync_d     = 1'b0;
          state_d    = S_REL;
        end
`ifdef HANDSHAKE_TIMEOUT_EN
        else if (phase_expired) begin
          sync_d  = 1'b0;
          error_d = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
`endif
      end
      S_REL: begin
        if (!hs.ack) begin
          count_d = count_inc;
          if (count_inc == n_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            sync_d  = 1'b1;
            state_d = S_REQ;
          end
        end
`ifdef HANDSHAKE_TIMEOUT_EN
        else if (phase_expired) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
`endif
      end
      default: begin
        // Bursts that ran handshakes already raised done on entry. A zero
        // length burst enters with done low and spends one extra cycle here
        // so its pulse appears one cycle after acceptance.
        if (done_q) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
    endcase
  end

`ifdef HANDSHAKE_TIMEOUT_EN
  // Phase counter restarts on every state change, so it measures time spent
  // waiting in the current REQ or REL phase.
  always_comb begin
    phase_d = '0;
    if ((state_d == state_q) && ((state_q == S_REQ) || (state_q == S_REL)))
      phase_d = phase_q + PH_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) phase_q <= '0;
    else       phase_q <= phase_d;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sync_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      result_q   <= '0;
      count_q    <= '0;
      n_q        <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      result_q   <= result_d;
      count_q    <= count_d;
      n_q        <= n_d;
      data_out_q <= data_out_d;
    end
  end

  assign hs.sync     = sync_q;
  assign hs.data_out = data_out_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign count       = count_q;
  assign state_dbg   = state_q;
`ifdef HANDSHAKE_TIMEOUT_EN
  assign error       = error_q;
`else
  assign error       = 1'b0;
`endif

endmodule

// File: doc/sync_master.md
# sync_master

Initiator side of the team's four-phase sync/ack handshake. On a start request it runs a programmable number of back-to-back transactions with a responder, such as the +1 counter block. Each transaction's result is fed back as the next transaction's operand, and the final result, a transaction count and completion/error status are reported to the local controller. It sits between the measurement controller and any handshake responder on the same clock.

## Interface
Parameters:
- OUT_WIDTH, 32, width of operand driven to responder
- IN_WIDTH, 32, width of result returned by responder
- N_WIDTH, 16, width of transaction count
- TIMEOUT_CYCLES, 1024, per-phase ack timeout (used only with HANDSHAKE_TIMEOUT_EN)

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a burst; sampled in IDLE only
- n_trans  in  N_WIDTH  number of transactions in the burst
- seed  in  OUT_WIDTH  operand for the first transaction
- busy  out  1  high from the start-accept edge until done
- done  out  1  one-cycle pulse at burst end
- error  out  1  burst aborted by timeout; held until the next accepted start
- result  out  IN_WIDTH  last captured responder data
- count  out  N_WIDTH  transactions completed in the current or last burst
- sync  out  1  handshake request to responder
- ack  in  1  handshake acknowledge from responder
- data_out  out  OUT_WIDTH  operand to responder
- data_in  in  IN_WIDTH  result from responder

## Operation
- Reset value of every output is 0; state is IDLE.
- Reset applied mid-transaction forces sync=0 immediately, without waiting for a clock edge.
- States:
  - IDLE
  - REQ: sync=1, waiting for ack=1
  - REL: sync=0, waiting for ack=0
  - DONE
- IDLE: start=1 and ack=0 at an edge accepts the burst:
  - latch data_out<=seed and remaining<=n_trans;
  - clear count and error; set busy.
  - If n_trans≠0, go to REQ with sync<=1.
  - If n_trans=0, go to DONE; no handshake is issued.
  - start is ignored while ack=1 in IDLE, or while busy.
- REQ: on ack=1:
  - result<=data_in;
  - data_out<=data_in, truncated to OUT_WIDTH or zero-extended if narrower;
  - sync<=0; go to REL.
- REL: on ack=0:
  - count<=count+1;
  - if count+1==n_trans, go to DONE; otherwise sync<=1 and go to REQ.
- DONE: done=1 for exactly one cycle; busy<=0; return to IDLE.
- data_out is stable whenever sync=1.
- sync never rises while ack=1.
- count does not wrap: its maximum is n_trans ≤ 2^N_WIDTH−1.
- ack and data_in are same-clock signals and are used unsynchronized.

## Timing
- Start accepted at edge E0 → sync=1 after E0.
- Against a responder that answers one edge after sync changes, each transaction takes 4 edges.
- Transaction k captures result at edge E0+4k−2.
- count increments at edge E0+4k.
- For a burst of N transactions, done is high in the cycle after edge E0+4N; busy falls with it.
- For n_trans=0, done is high in the cycle after E0+1.
- result and count are valid when done is high and hold until the next accepted start.

## Configuration
- HANDSHAKE_TIMEOUT_EN defined:
  - A phase counter clears on entry to REQ and to REL.
  - If it reaches TIMEOUT_CYCLES without the awaited ack level, the block sets sync<=0 and error<=1, goes to DONE (done pulse, busy falls), and leaves count at the completed-transaction value.
  - The next start is still gated by ack=0.
- HANDSHAKE_TIMEOUT_EN not defined:
  - No timeout counter; the block waits indefinitely.
  - error is tied to 0.

## Test plan
- Counter responder, seed=0, n_trans=5, start pulse → 5 handshakes; result=5, count=5; done pulse 20 cycles after the start edge; error=0.
- n_trans=0, seed=7 → no sync activity; done pulse 1 cycle after acceptance; count=0, result=0.
- start re-pulsed while busy during an n_trans=3 burst → ignored; exactly 3 handshakes; result=seed+3.
- Reset asserted while sync=1 mid-burst → sync, busy, done, result, count all 0 without a clock edge; a new start is accepted after reset release and ack=0.
- Responder stuck at ack=0, with HANDSHAKE_TIMEOUT_EN and TIMEOUT_CYCLES=16 → sync falls and error=1 within 17 cycles of sync rising; done pulse; count=0.
- Responder whose ack stays 1 in IDLE (HANDSHAKE_TIMEOUT_EN) → start ignored until ack=0, then the burst proceeds normally.
